// File: rtl/mainfsm_if.sv
// Decode inputs and datapath control outputs of the multicycle sequencer.
// The master side is the sequencer; the slave side is the datapath that consumes the controls.
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [3:0] State;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, State
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, State
    );
endinterface

// File: rtl/mainfsm.sv
// Multicycle ARM control sequencer: Moore FSM, controls are a combinational decode of the state.
// Advances one state per clock and has no stall input; Op/Funct matter only in DECODE and MEMADR.
module mainfsm (
    input  logic          clk,
    input  logic          reset,
    mainfsm_if.master     bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t state, next;

    // Only the immediate flag and the load/store bit steer the sequence.
    logic funct_unused;
    assign funct_unused = ^bus.Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   next = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = UNKNOWN;
                endcase
            end
            MEMADR:   next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp     = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        case (state)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.NextPC    = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR:   bus.ALUSrcB = 2'b01;
            MEMRD:    bus.AdrSrc  = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW      = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
            end
            EXECUTER: bus.ALUOp = 1'b1;
            EXECUTEI: begin
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 1'b1;
            end
            ALUWB:    bus.RegW = 1'b1;
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.State = state;

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
Multicycle control sequencer for the ARM processor. It decodes Op/Funct and steps each instruction through fetch, decode, execute, memory and writeback phases. It drives the datapath mux selects and the unconditioned write requests (RegW, MemW, NextPC, Branch). The conditional-execution logic gates these requests before they reach the register file, memory and PC.

Parameters:
none (state encoding fixed at 4 bits, decided below)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
Funct  input  6  instruction bits [25:20]; Funct[5]=immediate flag, Funct[0]=load(1)/store(0)
IRWrite  output  1  instruction register load enable
AdrSrc  output  1  memory address select: 0 PC, 1 ALU result register
ALUSrcA  output  1  ALU A select: 0 register read data, 1 PC
ALUSrcB  output  2  ALU B select: 00 register, 01 extended immediate, 10 constant 4
ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALU direct
ALUOp  output  1  1 = ALU decoder uses Funct, 0 = ADD
NextPC  output  1  unconditional PC write request
RegW  output  1  register write request (pre-condition)
MemW  output  1  memory write request (pre-condition)
Branch  output  1  conditional PC write request (PCS source)
State  output  4  current state code, for debug/verification

Behaviour:
- Moore FSM. One 4-bit state register clocked on posedge clk. All outputs are a pure combinational function of the state.
- Synchronous reset: on a clock edge with reset=1, the state becomes FETCH. While reset is held, outputs show the FETCH decode. The datapath registers are also in reset during this time, so the asserted IRWrite/NextPC are harmless.
- Reset asserted mid-instruction abandons the instruction. The next state is FETCH regardless of the current state or inputs.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11-15 are illegal.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=00, Funct[5]=0 -> EXECUTER
    - Op=00, Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> UNKNOWN
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER, EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH.
  - Illegal codes -> FETCH.
- Op/Funct are sampled only in DECODE and MEMADR. They are ignored in every other state.
- Output decode (any signal not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01
  - MEMRD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
  - UNKNOWN and illegal codes: all outputs 0
- Instruction latencies from FETCH to the next FETCH:
  - load: 5 cycles
  - store: 4 cycles
  - data-processing (register or immediate): 4 cycles
  - branch: 3 cycles
  - undefined: 3 cycles
- At most one of RegW, MemW, Branch is asserted in any cycle. IRWrite is asserted only in FETCH.
- No X propagation: every output has a defined value in every state code, including illegal codes.

Test Plan:
1. Reset held 3 cycles, then released with Op=00, Funct=000000 -> State=0 with IRWrite=1, NextPC=1, ALUSrcB=10; next cycle State=1; then 6, 8, 0. RegW=1 only in the State=8 cycle; ALUOp=1 in State=6.
2. Load: Op=01, Funct=011001 -> states 0,1,2,3,4,0. AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4; MemW stays 0 throughout.
3. Store: Op=01, Funct=011000 -> states 0,1,2,5,0. MemW=1 only in state 5 with AdrSrc=1; RegW stays 0.
4. Immediate data-processing (Op=00, Funct=101000) and branch (Op=10) -> states 0,1,7,8,0 with ALUSrcB=01 in state 7; then 0,1,9,0 with Branch=1 and ALUSrcB=01 in state 9.
5. Op=11 -> states 0,1,10,0 with all outputs 0 in state 10. Changing Op/Funct during states 3, 5, 8 and 9 does not alter the sequence.
6. Reset asserted for one cycle while in MEMRD (State=3) -> State=0 on the following edge; the load's MEMWB never occurs (RegW stays 0); the FSM then runs a normal FETCH/DECODE sequence.
